// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter
//   Shares a single-port data memory (registered read, one-cycle latency)
//   between the CPU load/store port and a DMA/debug port. Round-robin grant
//   evaluated only when idle; writes take 2 cycles, reads take 3 cycles.
//   Also counts CPU stall cycles, saturating at all-ones.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   cpu_req/we/addr/wdata         CPU request, held until cpu_ack
//   cpu_rdata, cpu_ack            CPU read data (held) and completion pulse
//   cpu_stall                     cpu_req & ~cpu_ack
//   dma_*                         same handshake for the DMA port
//   mem_rden/wren/addr/wdata      memory command, driven from registers
//   mem_q                         memory read data, valid cycle after mem_rden
//   stall_cycles                  saturating count of cpu_stall cycles
module dm_port_arbiter #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned MEM_BITS = 10,
   parameter int unsigned CNT_W    = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cpu_req,
   input  logic                cpu_we,
   input  logic [31:0]         cpu_addr,
   input  logic [DATA_W-1:0]   cpu_wdata,
   output logic [DATA_W-1:0]   cpu_rdata,
   output logic                cpu_ack,
   output logic                cpu_stall,
   input  logic                dma_req,
   input  logic                dma_we,
   input  logic [31:0]         dma_addr,
   input  logic [DATA_W-1:0]   dma_wdata,
   output logic [DATA_W-1:0]   dma_rdata,
   output logic                dma_ack,
   output logic                mem_rden,
   output logic                mem_wren,
   output logic [MEM_BITS-1:0] mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_q,
   output logic [CNT_W-1:0]    stall_cycles
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;
   typedef enum logic {PORT_CPU, PORT_DMA} port_e;

   state_e              state_q;
   port_e               last_grant_q;
   port_e               owner_q;
   logic                cmd_we_q;
   logic                cpu_ack_q;
   logic                dma_ack_q;
   logic [DATA_W-1:0]   cpu_rdata_q;
   logic [DATA_W-1:0]   dma_rdata_q;
   logic                mem_rden_q;
   logic                mem_wren_q;
   logic [MEM_BITS-1:0] mem_addr_q;
   logic [DATA_W-1:0]   mem_wdata_q;
   logic [CNT_W-1:0]    stall_q;

   logic                cpu_wins_d;
   port_e               winner_d;
   logic                win_we_d;
   logic [MEM_BITS-1:0] win_addr_d;
   logic [DATA_W-1:0]   win_wdata_d;
   logic [CNT_W-1:0]    stall_d;
   logic                addr_unused;

   // Upper address bits are intentionally discarded.
   assign addr_unused = ^{cpu_addr[31:MEM_BITS], dma_addr[31:MEM_BITS]};

   // CPU wins when alone, or on a tie when DMA had the previous grant.
   always_comb begin
      cpu_wins_d  = cpu_req & (~dma_req | (last_grant_q == PORT_DMA));
      winner_d    = cpu_wins_d ? PORT_CPU : PORT_DMA;
      win_we_d    = cpu_wins_d ? cpu_we : dma_we;
      win_addr_d  = cpu_wins_d ? cpu_addr[MEM_BITS-1:0] : dma_addr[MEM_BITS-1:0];
      win_wdata_d = cpu_wins_d ? cpu_wdata : dma_wdata;
   end

   always_comb begin
      stall_d = stall_q;
      if (cpu_stall && (stall_q != '1)) begin
         stall_d = stall_q + CNT_W'(1);
      end
   end

   // The mem_addr/mem_wdata registers double as the latched command: they are
   // loaded on the grant edge and hold until the next grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= PORT_DMA;
         owner_q      <= PORT_CPU;
         cmd_we_q     <= 1'b0;
         cpu_ack_q    <= 1'b0;
         dma_ack_q    <= 1'b0;
         cpu_rdata_q  <= '0;
         dma_rdata_q  <= '0;
         mem_rden_q   <= 1'b0;
         mem_wren_q   <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         stall_q      <= '0;
      end else begin
         stall_q    <= stall_d;
         cpu_ack_q  <= 1'b0;
         dma_ack_q  <= 1'b0;
         mem_rden_q <= 1'b0;
         mem_wren_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (cpu_req || dma_req) begin
                  owner_q      <= winner_d;
                  last_grant_q <= winner_d;
                  cmd_we_q     <= win_we_d;
                  mem_addr_q   <= win_addr_d;
                  mem_wdata_q  <= win_wdata_d;
                  mem_wren_q   <= win_we_d;
                  mem_rden_q   <= ~win_we_d;
                  // Writes complete during the ISSUE cycle itself.
                  cpu_ack_q    <= win_we_d & cpu_wins_d;
                  dma_ack_q    <= win_we_d & ~cpu_wins_d;
                  state_q      <= ISSUE;
               end
            end
            ISSUE: begin
               if (cmd_we_q) begin
                  state_q <= IDLE;
               end else begin
                  cpu_ack_q <= (owner_q == PORT_CPU);
                  dma_ack_q <= (owner_q == PORT_DMA);
                  state_q   <= RESP;
               end
            end
            RESP: begin
               if (owner_q == PORT_CPU) begin
                  cpu_rdata_q <= mem_q;
               end else begin
                  dma_rdata_q <= mem_q;
               end
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Read data is forwarded from mem_q during RESP and held in the register
   // afterwards, so it is valid in the same cycle as the ack.
   assign cpu_rdata = ((state_q == RESP) && (owner_q == PORT_CPU)) ? mem_q : cpu_rdata_q;
   assign dma_rdata = ((state_q == RESP) && (owner_q == PORT_DMA)) ? mem_q : dma_rdata_q;

   // Gating by rst keeps an access that is being reset from committing or acking.
   assign cpu_ack      = cpu_ack_q & ~rst;
   assign dma_ack      = dma_ack_q & ~rst;
   assign mem_rden     = mem_rden_q & ~rst;
   assign mem_wren     = mem_wren_q & ~rst;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;
   assign cpu_stall    = cpu_req & ~cpu_ack;
   assign stall_cycles = stall_q;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb_dm_port_arbiter
//   Directed scenarios plus randomized traffic on both ports against a
//   transaction-level model (grant cycle + fixed latencies, model memory).
module tb_dm_port_arbiter;

   localparam int DW = 32;
   localparam int MB = 10;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cpu_req = 1'b0, cpu_we = 1'b0;
   logic [31:0]   cpu_addr = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_ack, cpu_stall;
   logic          dma_req = 1'b0, dma_we = 1'b0;
   logic [31:0]   dma_addr = '0;
   logic [DW-1:0] dma_wdata = '0;
   logic [DW-1:0] dma_rdata;
   logic          dma_ack;
   logic          mem_rden, mem_wren;
   logic [MB-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_q;
   logic [CW-1:0] stall_cycles;

   always #5 clk = ~clk;

   dm_port_arbiter #(.DATA_W(DW), .MEM_BITS(MB), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_rdata(dma_rdata), .dma_ack(dma_ack),
      .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_q(mem_q), .stall_cycles(stall_cycles)
   );

   function automatic logic [31:0] init_val(input int i);
      return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
   endfunction

   // Single-port memory: registered read, one-cycle latency.
   logic [DW-1:0] ram [1024];
   initial begin
      mem_q = '0;
      for (int i = 0; i < 1024; i++) ram[i] = init_val(i);
      forever begin
         @(posedge clk);
         if (mem_wren) ram[mem_addr] = mem_wdata;
         if (mem_rden) mem_q <= ram[mem_addr];
      end
   end

   // ---------------- model state ----------------
   int            checks = 0;
   int            failures = 0;
   int            cyc = 0;
   int            busy_until = 0;
   bit            last_dma = 1'b1;
   bit            pv = 1'b0;
   bit            pport = 1'b0;
   bit            pwe = 1'b0;
   logic [MB-1:0] paddr = '0;
   logic [DW-1:0] pdata = '0;
   int            pgrant = 0;
   logic [MB-1:0] e_maddr = '0;
   logic [DW-1:0] e_mwdata = '0;
   logic [DW-1:0] e_rd [2];
   logic [CW-1:0] e_stall = '0;
   logic [DW-1:0] mmem [1024];
   bit            chk_en = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // One call per clock cycle, at the falling edge: compare, then advance.
   task automatic model_cycle();
      bit            strobe, ackc, ea_cpu, ea_dma, est;
      bit            w;
      logic [DW-1:0] rv, erc, erd;
      cyc++;
      strobe = pv && (cyc == pgrant + 1);
      ackc   = pv && (cyc == (pwe ? pgrant + 1 : pgrant + 2));
      ea_cpu = !rst && ackc && !pport;
      ea_dma = !rst && ackc && pport;
      rv     = mmem[paddr];
      erc    = (ackc && !pwe && !pport) ? rv : e_rd[0];
      erd    = (ackc && !pwe && pport)  ? rv : e_rd[1];
      est    = cpu_req && !ea_cpu;
      if (chk_en) begin
         chk("cpu_ack", 64'(cpu_ack), 64'(ea_cpu));
         chk("dma_ack", 64'(dma_ack), 64'(ea_dma));
         chk("ack_exclusive", 64'(cpu_ack & dma_ack), 64'(0));
         chk("cpu_stall", 64'(cpu_stall), 64'(est));
         chk("mem_wren", 64'(mem_wren), 64'(!rst && strobe && pwe));
         chk("mem_rden", 64'(mem_rden), 64'(!rst && strobe && !pwe));
         chk("mem_addr", 64'(mem_addr), 64'(e_maddr));
         chk("mem_wdata", 64'(mem_wdata), 64'(e_mwdata));
         chk("stall_cycles", 64'(stall_cycles), 64'(e_stall));
         if (!rst) begin
            chk("cpu_rdata", 64'(cpu_rdata), 64'(erc));
            chk("dma_rdata", 64'(dma_rdata), 64'(erd));
         end
      end
      if (rst) begin
         pv = 1'b0; busy_until = cyc + 1; last_dma = 1'b1;
         e_maddr = '0; e_mwdata = '0; e_rd[0] = '0; e_rd[1] = '0; e_stall = '0;
      end else begin
         if (strobe && pwe) mmem[paddr] = pdata;
         if (ackc && !pwe) e_rd[pport] = rv;
         if (ackc) pv = 1'b0;
         if (est && (e_stall != '1)) e_stall++;
         if ((cyc >= busy_until) && (cpu_req || dma_req)) begin
            w        = !(cpu_req && (!dma_req || last_dma));
            pv       = 1'b1;
            pport    = w;
            pwe      = w ? dma_we : cpu_we;
            paddr    = w ? dma_addr[MB-1:0] : cpu_addr[MB-1:0];
            pdata    = w ? dma_wdata : cpu_wdata;
            pgrant   = cyc;
            last_dma = w;
            busy_until = cyc + (pwe ? 2 : 3);
            e_maddr  = paddr;
            e_mwdata = pdata;
         end
      end
   endtask

   task automatic drive_edge();
      @(posedge clk); #1;
   endtask

   task automatic sample();
      @(negedge clk);
      model_cycle();
   endtask

   task automatic idle_cycle();
      drive_edge(); cpu_req = 1'b0; dma_req = 1'b0; sample();
   endtask

   task automatic do_reset();
      drive_edge(); rst = 1'b1; cpu_req = 1'b0; dma_req = 1'b0; sample();
      drive_edge(); rst = 1'b0; sample();
      chk_en = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int  ca, da, n;
      bit  both, cdone, ddone, cout, dout, cack, dack;
      int  ord [6];
      e_rd[0] = '0; e_rd[1] = '0;
      for (int i = 0; i < 1024; i++) mmem[i] = init_val(i);

      // --- reset state, write then read on the CPU port
      do_reset();
      chk("rst_cpu_ack", 64'(cpu_ack), 64'(0));
      chk("rst_stall_cnt", 64'(stall_cycles), 64'(0));
      chk("rst_mem_addr", 64'(mem_addr), 64'(0));
      drive_edge(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h5; cpu_wdata = 32'hDEADBEEF; sample();
      chk("s1_wr_noack_n", 64'(cpu_ack), 64'(0));
      drive_edge(); sample();
      chk("s1_wr_wren", 64'(mem_wren), 64'(1));
      chk("s1_wr_addr", 64'(mem_addr), 64'(5));
      chk("s1_wr_wdata", 64'(mem_wdata), 64'(32'hDEADBEEF));
      chk("s1_wr_ack", 64'(cpu_ack), 64'(1));
      drive_edge(); cpu_req = 1'b0; sample();
      chk("s1_cnt_after_wr", 64'(stall_cycles), 64'(1));
      drive_edge(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h5; cpu_wdata = '0; sample();
      drive_edge(); sample();
      chk("s1_rd_rden", 64'(mem_rden), 64'(1));
      chk("s1_rd_noack", 64'(cpu_ack), 64'(0));
      drive_edge(); sample();
      chk("s1_rd_ack", 64'(cpu_ack), 64'(1));
      chk("s1_rd_data", 64'(cpu_rdata), 64'(32'hDEADBEEF));
      drive_edge(); cpu_req = 1'b0; sample();
      chk("s1_cnt_after_rd", 64'(stall_cycles), 64'(3));
      chk("s1_rd_hold", 64'(cpu_rdata), 64'(32'hDEADBEEF));

      // --- simultaneous reads after reset
      do_reset();
      ca = -1; da = -1; both = 1'b0; cdone = 1'b0; ddone = 1'b0;
      for (int k = 0; k < 12; k++) begin
         drive_edge();
         cpu_req = !cdone; cpu_we = 1'b0; cpu_addr = 32'h20;
         dma_req = !ddone; dma_we = 1'b0; dma_addr = 32'h21;
         sample();
         if (cpu_ack) begin ca = k; cdone = 1'b1; end
         if (dma_ack) begin da = k; ddone = 1'b1; end
         if (cpu_ack && dma_ack) both = 1'b1;
      end
      chk("s2_cpu_ack_cycle", 64'(ca), 64'(2));
      chk("s2_dma_ack_cycle", 64'(da), 64'(5));
      chk("s2_never_both", 64'(both), 64'(0));
      chk("s2_cpu_data", 64'(cpu_rdata), 64'(init_val(32'h20)));
      chk("s2_dma_data", 64'(dma_rdata), 64'(init_val(32'h21)));

      // --- sustained contention alternates strictly
      do_reset();
      n = 0;
      for (int k = 0; k < 40 && n < 6; k++) begin
         drive_edge();
         cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h30 + 32'(n); cpu_wdata = 32'(k);
         dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h40 + 32'(n); dma_wdata = 32'(k) + 32'h100;
         sample();
         if (cpu_ack && n < 6) begin ord[n] = 0; n++; end
         if (dma_ack && n < 6) begin ord[n] = 1; n++; end
      end
      idle_cycle();
      chk("s3_ack_count", 64'(n), 64'(6));
      for (int i = 0; i < 6; i++) chk($sformatf("s3_grant%0d", i), 64'(ord[i]), 64'(i % 2));

      // --- address truncation
      do_reset();
      drive_edge(); dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h401; dma_wdata = 32'h7; sample();
      drive_edge(); sample();
      chk("s4_wren", 64'(mem_wren), 64'(1));
      chk("s4_addr_trunc", 64'(mem_addr), 64'(1));
      chk("s4_dma_ack", 64'(dma_ack), 64'(1));
      drive_edge(); dma_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1; sample();
      drive_edge(); sample();
      drive_edge(); sample();
      chk("s4_cpu_ack", 64'(cpu_ack), 64'(1));
      chk("s4_cpu_data", 64'(cpu_rdata), 64'(7));
      idle_cycle();

      // --- reset during a write's ISSUE cycle
      do_reset();
      drive_edge(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h9; cpu_wdata = 32'hAAAA5555; sample();
      drive_edge(); rst = 1'b1; sample();
      chk("s5_wren_gated", 64'(mem_wren), 64'(0));
      chk("s5_no_ack", 64'(cpu_ack), 64'(0));
      drive_edge(); rst = 1'b0; cpu_req = 1'b0; sample();
      chk("s5_ack_after", 64'(cpu_ack), 64'(0));
      chk("s5_addr_after", 64'(mem_addr), 64'(0));
      chk("s5_wdata_after", 64'(mem_wdata), 64'(0));
      chk("s5_cnt_after", 64'(stall_cycles), 64'(0));
      drive_edge(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h9; sample();
      drive_edge(); sample();
      drive_edge(); sample();
      chk("s5_rd_ack", 64'(cpu_ack), 64'(1));
      chk("s5_word_unchanged", 64'(cpu_rdata), 64'(init_val(9)));
      idle_cycle();

      // --- stall counter saturation
      do_reset();
      for (int k = 0; k < 40; k++) begin
         drive_edge();
         cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h50;
         dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h60; dma_wdata = 32'(k);
         sample();
      end
      chk("s6_saturated", 64'(stall_cycles), 64'(15));
      idle_cycle();

      // --- randomized traffic with occasional resets
      do_reset();
      cout = 1'b0; dout = 1'b0; cack = 1'b0; dack = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         drive_edge();
         rst = ($urandom_range(0, 199) == 0);
         if (cout && cack) cout = 1'b0;
         if (!cout) begin
            if ($urandom_range(0, 1) == 1) begin
               cout = 1'b1; cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
               cpu_addr = ($urandom & 32'hFFFF_FC00) | $urandom_range(0, 15);
               cpu_wdata = $urandom;
            end else cpu_req = 1'b0;
         end else if ($urandom_range(0, 39) == 0) begin
            cout = 1'b0; cpu_req = 1'b0;
         end else if ($urandom_range(0, 19) == 0) begin
            cpu_addr = $urandom_range(0, 15); cpu_wdata = $urandom;
         end
         if (dout && dack) dout = 1'b0;
         if (!dout) begin
            if ($urandom_range(0, 1) == 1) begin
               dout = 1'b1; dma_req = 1'b1; dma_we = 1'($urandom_range(0, 1));
               dma_addr = ($urandom & 32'hFFFF_FC00) | $urandom_range(0, 15);
               dma_wdata = $urandom;
            end else dma_req = 1'b0;
         end else if ($urandom_range(0, 39) == 0) begin
            dout = 1'b0; dma_req = 1'b0;
         end else if ($urandom_range(0, 19) == 0) begin
            dma_addr = $urandom_range(0, 15); dma_wdata = $urandom;
         end
         sample();
         cack = cpu_ack; dack = dma_ack;
      end
      drive_edge(); rst = 1'b0; cpu_req = 1'b0; dma_req = 1'b0; sample();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Shares the single-port data memory (registered read, one-cycle latency, rden/wren strobes) between the CPU load/store port and a DMA/debug port.
- Request/ack handshake on each side; round-robin grant; drives the memory strobes, address and write data from registers.
- Sits between the CPU bus outputs (address, write data, control) and the data memory; also exposes a saturating CPU stall-cycle counter for performance monitoring.

Parameters:
- DATA_W, 32, data width of both ports and the memory.
- MEM_BITS, 10, memory address width; requester addresses are truncated to the low MEM_BITS bits.
- CNT_W, 32, width of the stall counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req.
- cpu_addr  in  32  word address.
- cpu_wdata  in  DATA_W  write data.
- cpu_rdata  out  DATA_W  read data; valid when cpu_ack and the access was a read.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_stall  out  1  = cpu_req & ~cpu_ack (combinational).
- dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_ack: same as cpu_* for the DMA port.
- mem_rden  out  1  memory read strobe.
- mem_wren  out  1  memory write strobe.
- mem_addr  out  MEM_BITS  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_q  in  DATA_W  memory read data; valid the cycle after mem_rden.
- stall_cycles  out  CNT_W  saturating count of cycles with cpu_stall = 1.

Behaviour:
- Reset (rst = 1 at an edge):
  - state = IDLE; last_grant = DMA, so the CPU wins the first tie.
  - All outputs registered to 0: acks, rdata, mem_*, stall_cycles.
  - mem_rden and mem_wren are additionally gated by ~rst, so no memory write commits in any cycle where rst = 1.
  - Reset mid-access aborts the access; no ack is produced.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - Only one requester active: it wins.
  - Both active: the port not equal to last_grant wins.
  - On a win: latch winner, we, addr[MEM_BITS-1:0] and wdata into the command registers; update last_grant; go to ISSUE.
  - No request: stay in IDLE.
- ISSUE (one cycle):
  - Drive mem_addr and mem_wdata; assert exactly one of mem_wren or mem_rden.
  - Write: the winner's ack = 1 this cycle; next state IDLE.
  - Read: next state RESP.
- RESP (one cycle): winner's rdata = mem_q (registered hold), winner's ack = 1; next state IDLE.
- Latency from IDLE with req sampled in cycle N:
  - Write: ack in cycle N+1; 2 cycles per write.
  - Read: ack and data in cycle N+2; 3 cycles per read.
- Handshake rules:
  - The requester keeps req and payload stable until ack.
  - If req is still high in the cycle after ack, it is a new request.
  - Dropping req after a grant does not cancel the access; the ack still pulses.
  - Payload changes after the IDLE sample are ignored, because the command is latched.
- Arbitration is evaluated only in IDLE. Under sustained contention grants alternate strictly: CPU, DMA, CPU, ...
- Exclusivity: cpu_ack and dma_ack are never high together; mem_rden and mem_wren are never high together.
- rdata retains its last read value until the next read completes on that port; write acks do not change it.
- Outside ISSUE: mem_rden = mem_wren = 0; mem_addr and mem_wdata hold their last values.
- stall_cycles increments each cycle cpu_stall = 1 and saturates at all-ones; it is cleared only by rst.

Test Plan:
- After reset, CPU write addr 0x5, data 0xDEADBEEF: mem_wren = 1 with mem_addr = 5 in cycle N+1; cpu_ack in N+1. Then CPU read addr 5: cpu_rdata = 0xDEADBEEF with cpu_ack in N+2; stall_cycles = 1 after the write and 3 after the read (2 more).
- cpu_req and dma_req both rise in the same cycle after reset, both reads: CPU acked first; DMA acked 3 cycles later; never both acks high.
- Both ports hold req continuously for 6 accesses: grant order is CPU, DMA, CPU, DMA, CPU, DMA.
- DMA write addr 0x401 (MEM_BITS = 10), data 7: mem_addr = 0x001; a CPU read of addr 1 returns 7.
- rst asserted during a CPU write's ISSUE cycle: mem_wren = 0 in that cycle; no cpu_ack; memory word unchanged; outputs 0 after the edge.
- CPU req held for 2^CNT_W+ cycles (bench with CNT_W = 4 and DMA hogging): stall_cycles stops at 15.
